instruction_fetch_unit: RTL

Fetch stage of the pipelined MIPS core, directly upstream of `InstructionMemory`. Holds the program counter, drives the word address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Accepts stall from the hazard unit, PC redirects from the branch/jump resolution stage, and a halt request. Keeps a saturating count of fetched instructions.

---
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, addresses the combinational instruction memory and
// captures the returned word into the IF/ID register. Handles stall, redirect and halt.
module instruction_fetch_unit #(
    parameter int unsigned             ADDR_WIDTH = 7,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]   NOP        = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectTarget,
    input  logic                  Halt,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [ADDR_WIDTH-1:0] IFID_PC,
    output logic [ADDR_WIDTH-1:0] IFID_PCNext,
    output logic                  IFID_Valid,
    output logic [15:0]           FetchCount,
    output logic                  Halted
);

    localparam int unsigned COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [DATA_WIDTH-1:0]  ifid_instr_q, ifid_instr_d;
    logic [ADDR_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
    logic [ADDR_WIDTH-1:0]  ifid_pcnext_q, ifid_pcnext_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic [COUNT_W-1:0]     fetch_count_q, fetch_count_d;
    logic                   halted_q, halted_d;
    logic [ADDR_WIDTH-1:0]  pc_inc;

    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            ifid_instr_q  <= NOP;
            ifid_pc_q     <= '0;
            ifid_pcnext_q <= '0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pcnext_q <= ifid_pcnext_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   state_d = ST_RUN;
            ST_RUN:    if (Halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath updates; priority in RUN is halt > redirect > stall > fetch
    always_comb begin
        pc_d          = pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pcnext_d = ifid_pcnext_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        halted_d      = (state_d == ST_HALTED);
        if (state_q == ST_RUN) begin
            if (Halt || Redirect) begin
                ifid_instr_d  = NOP;
                ifid_pc_d     = '0;
                ifid_pcnext_d = '0;
                ifid_valid_d  = 1'b0;
                if (!Halt) begin
                    pc_d = RedirectTarget;
                end
            end else if (!Stall) begin
                ifid_instr_d  = Instruction;
                ifid_pc_d     = pc_q;
                ifid_pcnext_d = pc_inc;
                ifid_valid_d  = 1'b1;
                pc_d          = pc_inc;
                if (fetch_count_q != COUNT_MAX) begin
                    fetch_count_d = fetch_count_q + COUNT_W'(1);
                end
            end
        end
    end

    assign Address          = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_PCNext      = ifid_pcnext_q;
    assign IFID_Valid       = ifid_valid_q;
    assign FetchCount       = fetch_count_q;
    assign Halted           = halted_q;

endmodule
